// File: rtl/ucsbece154b_bpred_gshare_ras.sv
// rtl/ucsbece154b_bpred_gshare_ras.sv - gshare direction predictor with tagged BTB and return address stack
module ucsbece154b_bpred_gshare_ras #(
    parameter int NUM_BTB_ENTRIES = 32,
    parameter int NUM_GHR_BITS    = 5,
    parameter int CTR_BITS        = 2,
    parameter int TAG_BITS        = 16,
    parameter int RAS_DEPTH       = 8
) (
    input  logic                                                 clk,
    input  logic                                                 reset_ni,
    input  logic                                                 fetch_valid_i,
    input  logic [31:0]                                          pc_i,
    output logic                                                 predict_hit_o,
    output logic                                                 predict_taken_o,
    output logic [31:0]                                          predict_target_o,
    output logic [NUM_GHR_BITS-1:0]                              pred_ghr_o,
    output logic [$clog2(RAS_DEPTH)+$clog2(RAS_DEPTH+1)-1:0]     pred_ras_o,
    input  logic                                                 upd_valid_i,
    input  logic [31:0]                                          upd_pc_i,
    input  logic [31:0]                                          upd_target_i,
    input  logic [1:0]                                           upd_kind_i,
    input  logic                                                 upd_taken_i,
    input  logic                                                 upd_mispredict_i,
    input  logic [NUM_GHR_BITS-1:0]                              upd_ghr_i,
    input  logic [$clog2(RAS_DEPTH)+$clog2(RAS_DEPTH+1)-1:0]     upd_ras_i
);
    localparam int IDX         = $clog2(NUM_BTB_ENTRIES);
    localparam int RP          = $clog2(RAS_DEPTH);
    localparam int RC          = $clog2(RAS_DEPTH + 1);
    localparam int N           = NUM_GHR_BITS;
    localparam int PHT_ENTRIES = 1 << N;

    localparam logic [1:0] KIND_BR   = 2'b00;
    localparam logic [1:0] KIND_CALL = 2'b10;
    localparam logic [1:0] KIND_RET  = 2'b11;

    localparam logic [CTR_BITS-1:0] CTR_INIT = {1'b0, {(CTR_BITS-1){1'b1}}};
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [RC-1:0]       RAS_FULL = RC'(RAS_DEPTH);

    logic [NUM_BTB_ENTRIES-1:0] btb_valid;
    logic [TAG_BITS-1:0]        btb_tag    [NUM_BTB_ENTRIES];
    logic [31:0]                btb_target [NUM_BTB_ENTRIES];
    logic [1:0]                 btb_kind   [NUM_BTB_ENTRIES];
    logic [CTR_BITS-1:0]        pht        [PHT_ENTRIES];
    logic [N-1:0]               ghr;
    logic [31:0]                ras_data   [RAS_DEPTH];
    logic [RP-1:0]              ras_ptr;
    logic [RC-1:0]              ras_cnt;

    // Fetch-side lookup
    logic [IDX-1:0]      look_idx;
    logic [TAG_BITS-1:0] look_tag;
    logic [N-1:0]        look_pht_idx;
    logic [1:0]          look_kind;
    logic [RP-1:0]       ras_ptr_dec;

    assign look_idx     = pc_i[IDX+1:2];
    assign look_tag     = pc_i[TAG_BITS+IDX+1:IDX+2];
    assign look_pht_idx = pc_i[N+1:2] ^ ghr;
    assign look_kind    = btb_kind[look_idx];
    assign ras_ptr_dec  = ras_ptr - RP'(1);

    assign predict_hit_o = btb_valid[look_idx] && (btb_tag[look_idx] == look_tag);
    assign pred_ghr_o    = ghr;
    assign pred_ras_o    = {ras_ptr, ras_cnt};

    always_comb begin
        predict_taken_o  = 1'b0;
        predict_target_o = 32'd0;
        if (predict_hit_o) begin
            predict_target_o = btb_target[look_idx];
            case (look_kind)
                KIND_BR:  predict_taken_o = pht[look_pht_idx][CTR_BITS-1];
                KIND_RET: begin
                    predict_taken_o = 1'b1;
                    if (ras_cnt != '0)
                        predict_target_o = ras_data[ras_ptr_dec];
                end
                default:  predict_taken_o = 1'b1;
            endcase
        end
    end

    // Execute-side training indices and checkpoint fields
    logic [IDX-1:0]      upd_idx;
    logic [TAG_BITS-1:0] upd_tag;
    logic [N-1:0]        upd_pht_idx;
    logic [CTR_BITS-1:0] upd_ctr_cur;
    logic [CTR_BITS-1:0] upd_ctr_next;
    logic [RP-1:0]       chk_ptr;
    logic [RC-1:0]       chk_cnt;

    assign upd_idx     = upd_pc_i[IDX+1:2];
    assign upd_tag     = upd_pc_i[TAG_BITS+IDX+1:IDX+2];
    assign upd_pht_idx = upd_pc_i[N+1:2] ^ upd_ghr_i;
    assign upd_ctr_cur = pht[upd_pht_idx];
    assign chk_ptr     = upd_ras_i[RP+RC-1:RC];
    assign chk_cnt     = upd_ras_i[RC-1:0];

    always_comb begin
        upd_ctr_next = upd_ctr_cur;
        if (upd_taken_i && (upd_ctr_cur != CTR_MAX))
            upd_ctr_next = upd_ctr_cur + CTR_BITS'(1);
        else if (!upd_taken_i && (upd_ctr_cur != '0))
            upd_ctr_next = upd_ctr_cur - CTR_BITS'(1);
    end

    // Speculative GHR/RAS next state; a repair overrides whatever fetch wanted to do
    logic          repair;
    logic          spec;
    logic [N-1:0]  ghr_next;
    logic [RP-1:0] ptr_next;
    logic [RC-1:0] cnt_next;
    logic          push;
    logic [RP-1:0] push_ptr;
    logic [31:0]   push_data;

    assign repair = upd_valid_i && upd_mispredict_i;
    assign spec   = fetch_valid_i && predict_hit_o && !repair;

    always_comb begin
        ghr_next  = ghr;
        ptr_next  = ras_ptr;
        cnt_next  = ras_cnt;
        push      = 1'b0;
        push_ptr  = ras_ptr;
        push_data = pc_i + 32'd4;
        if (repair) begin
            ghr_next = (upd_kind_i == KIND_BR) ? {upd_ghr_i[N-2:0], upd_taken_i} : upd_ghr_i;
            ptr_next = chk_ptr;
            cnt_next = chk_cnt;
            if (upd_kind_i == KIND_CALL) begin
                push      = 1'b1;
                push_ptr  = chk_ptr;
                push_data = upd_pc_i + 32'd4;
                ptr_next  = chk_ptr + RP'(1);
                cnt_next  = (chk_cnt == RAS_FULL) ? chk_cnt : chk_cnt + RC'(1);
            end else if ((upd_kind_i == KIND_RET) && (chk_cnt != '0)) begin
                ptr_next = chk_ptr - RP'(1);
                cnt_next = chk_cnt - RC'(1);
            end
        end else if (spec) begin
            case (look_kind)
                KIND_BR:   ghr_next = {ghr[N-2:0], predict_taken_o};
                KIND_CALL: begin
                    push     = 1'b1;
                    ptr_next = ras_ptr + RP'(1);
                    cnt_next = (ras_cnt == RAS_FULL) ? ras_cnt : ras_cnt + RC'(1);
                end
                KIND_RET: begin
                    if (ras_cnt != '0) begin
                        ptr_next = ras_ptr_dec;
                        cnt_next = ras_cnt - RC'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            ghr       <= '0;
            ras_ptr   <= '0;
            ras_cnt   <= '0;
            btb_valid <= '0;
            for (int i = 0; i < PHT_ENTRIES; i++)
                pht[i] <= CTR_INIT;
        end else begin
            ghr     <= ghr_next;
            ras_ptr <= ptr_next;
            ras_cnt <= cnt_next;
            if (upd_valid_i) begin
                if (upd_kind_i == KIND_BR)
                    pht[upd_pht_idx] <= upd_ctr_next;
                if (upd_taken_i)
                    btb_valid[upd_idx] <= 1'b1;
            end
        end
    end

    // Payload storage carries no reset; validity alone qualifies it
    always_ff @(posedge clk) begin
        if (upd_valid_i && upd_taken_i) begin
            btb_tag[upd_idx]    <= upd_tag;
            btb_target[upd_idx] <= upd_target_i;
            btb_kind[upd_idx]   <= upd_kind_i;
        end
        if (push)
            ras_data[push_ptr] <= push_data;
    end

endmodule

// File: tb/tb_ucsbece154b_bpred_gshare_ras.sv
// tb/tb_ucsbece154b_bpred_gshare_ras.sv - directed self-checking bench for the gshare/BTB/RAS predictor
module tb_ucsbece154b_bpred_gshare_ras;
    logic        clk = 1'b0;
    logic        reset_ni;
    logic        fetch_valid;
    logic [31:0] pc;
    logic        hit;
    logic        taken;
    logic [31:0] target;
    logic [4:0]  pred_ghr;
    logic [6:0]  pred_ras;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic [1:0]  upd_kind;
    logic        upd_taken;
    logic        upd_mispredict;
    logic [4:0]  upd_ghr;
    logic [6:0]  upd_ras;

    int checks = 0;
    int errors = 0;

    ucsbece154b_bpred_gshare_ras dut (
        .clk              (clk),
        .reset_ni         (reset_ni),
        .fetch_valid_i    (fetch_valid),
        .pc_i             (pc),
        .predict_hit_o    (hit),
        .predict_taken_o  (taken),
        .predict_target_o (target),
        .pred_ghr_o       (pred_ghr),
        .pred_ras_o       (pred_ras),
        .upd_valid_i      (upd_valid),
        .upd_pc_i         (upd_pc),
        .upd_target_i     (upd_target),
        .upd_kind_i       (upd_kind),
        .upd_taken_i      (upd_taken),
        .upd_mispredict_i (upd_mispredict),
        .upd_ghr_i        (upd_ghr),
        .upd_ras_i        (upd_ras)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic upd(input logic [31:0] p, input logic [31:0] t, input logic [1:0] k,
                       input logic tk, input logic mis, input logic [4:0] g, input logic [6:0] r);
        upd_valid = 1'b1; upd_pc = p; upd_target = t; upd_kind = k;
        upd_taken = tk; upd_mispredict = mis; upd_ghr = g; upd_ras = r;
        @(negedge clk); #1;
        upd_valid = 1'b0; upd_mispredict = 1'b0;
    endtask

    task automatic look(input logic [31:0] p);
        fetch_valid = 1'b0; pc = p; #1;
    endtask

    task automatic fetch(input logic [31:0] p);
        pc = p; fetch_valid = 1'b1;
        @(negedge clk); #1;
        fetch_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $error("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        reset_ni = 1'b0; fetch_valid = 1'b0; pc = 32'h100;
        upd_valid = 1'b0; upd_pc = '0; upd_target = '0; upd_kind = '0;
        upd_taken = 1'b0; upd_mispredict = 1'b0; upd_ghr = '0; upd_ras = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_hit", 32'(hit), 32'd0);
        chk("rst_taken", 32'(taken), 32'd0);
        chk("rst_target", target, 32'd0);
        chk("rst_ghr", 32'(pred_ghr), 32'd0);
        chk("rst_ras", 32'(pred_ras), 32'd0);
        reset_ni = 1'b1;
        @(negedge clk); #1;
        look(32'h100);
        chk("post_rst_hit", 32'(hit), 32'd0);
        chk("post_rst_taken", 32'(taken), 32'd0);
        chk("post_rst_target", target, 32'd0);
        chk("post_rst_ghr", 32'(pred_ghr), 32'd0);
        chk("post_rst_ras", 32'(pred_ras), 32'd0);

        // Branch training: PHT[16] 1 -> 2 -> 3
        upd(32'h40, 32'h80, 2'b00, 1'b1, 1'b0, 5'd0, 7'h00);
        upd(32'h40, 32'h80, 2'b00, 1'b1, 1'b0, 5'd0, 7'h00);
        look(32'h40);
        chk("br_hit", 32'(hit), 32'd1);
        chk("br_taken", 32'(taken), 32'd1);
        chk("br_target", target, 32'h80);
        look(32'hC0);
        chk("tag_miss_hit", 32'(hit), 32'd0);
        chk("tag_miss_target", target, 32'd0);
        fetch(32'h40);
        look(32'h100);
        chk("br_fetch_ghr", 32'(pred_ghr), 32'd1);

        // Non-link jump repair restores GHR verbatim
        upd(32'h2008, 32'h3000, 2'b01, 1'b1, 1'b1, 5'd0, 7'h00);
        look(32'h100);
        chk("jal_repair_ghr", 32'(pred_ghr), 32'd0);

        // Saturation: 5 not-taken drive PHT[16] to 0
        for (int i = 0; i < 5; i++)
            upd(32'h40, 32'h80, 2'b00, 1'b0, 1'b0, 5'd0, 7'h00);
        look(32'h40);
        chk("sat_hit", 32'(hit), 32'd1);
        chk("sat_taken", 32'(taken), 32'd0);
        chk("sat_target", target, 32'h80);
        upd(32'h40, 32'h80, 2'b00, 1'b1, 1'b0, 5'd0, 7'h00);
        look(32'h40);
        chk("sat_plus1_taken", 32'(taken), 32'd0);
        upd_valid = 1'b1; upd_pc = 32'h40; upd_target = 32'h80; upd_kind = 2'b00;
        upd_taken = 1'b1; upd_mispredict = 1'b0; upd_ghr = 5'd0;
        look(32'h40);
        chk("no_bypass_taken", 32'(taken), 32'd0);
        @(negedge clk); #1;
        upd_valid = 1'b0;
        look(32'h40);
        chk("sat_plus2_taken", 32'(taken), 32'd1);

        // RAS basics
        upd(32'h10, 32'h300, 2'b10, 1'b1, 1'b0, 5'd0, 7'h00);
        upd(32'h200, 32'h400, 2'b11, 1'b1, 1'b0, 5'd0, 7'h00);
        look(32'h200);
        chk("ret_empty_hit", 32'(hit), 32'd1);
        chk("ret_empty_taken", 32'(taken), 32'd1);
        chk("ret_empty_target", target, 32'h400);
        look(32'h10);
        chk("call_taken", 32'(taken), 32'd1);
        chk("call_target", target, 32'h300);
        fetch(32'h10);
        look(32'h200);
        chk("ras_push_state", 32'(pred_ras), 32'h11);
        chk("ret_ras_target", target, 32'h14);
        fetch(32'h200);
        look(32'h200);
        chk("ras_pop_state", 32'(pred_ras), 32'h00);
        chk("ret_fallback_target", target, 32'h400);
        fetch(32'h200);
        look(32'h200);
        chk("ras_underflow_state", 32'(pred_ras), 32'h00);

        // Overflow: calls at 4*i push 4*i+4; the 9th overwrites the oldest
        for (int i = 1; i <= 9; i++)
            upd(32'(4 * i), 32'h500, 2'b10, 1'b1, 1'b0, 5'd0, 7'h00);
        for (int i = 1; i <= 9; i++)
            fetch(32'(4 * i));
        look(32'h200);
        chk("ovf_state", 32'(pred_ras), 32'h18);
        for (int k = 0; k < 8; k++) begin
            look(32'h200);
            chk($sformatf("ovf_ret%0d_target", k), target, 32'(32'h28 - 4 * k));
            fetch(32'h200);
        end
        look(32'h200);
        chk("ovf_ret8_target", target, 32'h400);
        chk("ovf_drained_state", 32'(pred_ras), 32'h10);

        // Speculative history, then repair racing a fetch
        fetch(32'h40);
        fetch(32'h40);
        fetch(32'h40);
        look(32'h100);
        chk("spec3_ghr", 32'(pred_ghr), 32'd4);
        pc = 32'h40; fetch_valid = 1'b1;
        upd_valid = 1'b1; upd_pc = 32'h40; upd_target = 32'h80; upd_kind = 2'b00;
        upd_taken = 1'b1; upd_mispredict = 1'b1; upd_ghr = 5'b00010; upd_ras = 7'h10;
        #1;
        chk("race_fetch_hit", 32'(hit), 32'd1);
        @(negedge clk); #1;
        fetch_valid = 1'b0; upd_valid = 1'b0; upd_mispredict = 1'b0;
        look(32'h100);
        chk("repair_ghr", 32'(pred_ghr), 32'd5);
        chk("repair_ras_kept", 32'(pred_ras), 32'h10);

        // RAS repair: restore then apply own push/pop
        upd(32'h10, 32'h300, 2'b10, 1'b1, 1'b1, 5'd5, {3'd3, 4'd2});
        look(32'h200);
        chk("repair_call_state", 32'(pred_ras), 32'h43);
        chk("repair_call_target", target, 32'h14);
        chk("repair_call_ghr", 32'(pred_ghr), 32'd5);
        upd(32'h200, 32'h400, 2'b11, 1'b1, 1'b1, 5'd5, 7'h43);
        look(32'h100);
        chk("repair_ret_state", 32'(pred_ras), 32'h32);
        upd(32'h200, 32'h400, 2'b11, 1'b1, 1'b1, 5'd5, {3'd2, 4'd0});
        look(32'h100);
        chk("repair_ret_empty_state", 32'(pred_ras), 32'h20);

        // Asynchronous reset away from any clock edge
        look(32'h40);
        #2 reset_ni = 1'b0;
        #1;
        chk("async_rst_hit", 32'(hit), 32'd0);
        chk("async_rst_ghr", 32'(pred_ghr), 32'd0);
        chk("async_rst_ras", 32'(pred_ras), 32'd0);
        @(negedge clk);
        reset_ni = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
